regfile_mp: RTL

Parametrised multi-read-port integer register file with a built-in clear sequencer and a per-register pending scoreboard. It replaces the fixed 2-read/1-write 32×32 register file in the core's decode stage. It adds optional write-to-read bypass and a pending bit per register, which lets the pipeline hazard unit stall on in-flight writebacks. Register 0 reads as zero and is never written or marked pending.

---
 rtl/regfile_mp_if.sv | 29 ++
 rtl/regfile_mp.sv | 93 +++++++++
 2 files changed

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, writeback, issue and init status.
// The core side uses the master modport; the register file uses the slave modport.
interface regfile_mp_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NREAD = 2
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [NREAD*AW-1:0]   rd_addr;
    logic [NREAD*XLEN-1:0] rd_data;
    logic [NREAD-1:0]      rd_pending;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [XLEN-1:0]       wr_data;
    logic                  iss_en;
    logic [AW-1:0]         iss_addr;
    logic                  init_busy;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_pending, init_busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_pending, init_busy
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with a clear sequencer after reset, optional
// write-to-read bypass and a per-register pending scoreboard. r0 is hardwired to zero.
module regfile_mp #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned NREAD  = 2,
    parameter bit          BYPASS = 1'b1
) (
    input logic         clk,
    input logic         rst,
    regfile_mp_if.slave bus
);
    localparam int unsigned AW = $clog2(NREGS);

    typedef enum logic [0:0] {StClear, StIdle} state_e;

    state_e                state_q, state_d;
    logic [AW-1:0]         ptr_q, ptr_d;
    logic [NREGS-1:0]      pend_q, pend_d;
    logic [XLEN-1:0]       regs_q [1:NREGS-1];
    logic [AW-1:0]         raddr;
    logic [NREAD*XLEN-1:0] rdata;
    logic [NREAD-1:0]      rpend;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StClear;
            ptr_q   <= AW'(1);
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            pend_q  <= pend_d;
        end
    end

    // Storage has no reset; the clear sequencer zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == StClear) begin
                regs_q[ptr_q] <= '0;
            end else if (bus.wr_en && bus.wr_addr != '0) begin
                regs_q[bus.wr_addr] <= bus.wr_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        pend_d  = pend_q;
        unique case (state_q)
            StClear: begin
                if (ptr_q == AW'(NREGS - 1)) begin
                    state_d = StIdle;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            StIdle: begin
                if (bus.wr_en) begin
                    pend_d[bus.wr_addr] = 1'b0;
                end
                // Issue after writeback so a new producer supersedes the old one.
                if (bus.iss_en) begin
                    pend_d[bus.iss_addr] = 1'b1;
                end
                pend_d[0] = 1'b0;
            end
        endcase
    end

    always_comb begin
        rdata = '0;
        rpend = '0;
        raddr = '0;
        for (int unsigned p = 0; p < NREAD; p++) begin
            raddr = bus.rd_addr[p*AW +: AW];
            if (state_q == StIdle && raddr != '0) begin
                if (BYPASS && bus.wr_en && bus.wr_addr == raddr) begin
                    rdata[p*XLEN +: XLEN] = bus.wr_data;
                end else begin
                    rdata[p*XLEN +: XLEN] = regs_q[raddr];
                    rpend[p]              = pend_q[raddr];
                end
            end
        end
    end

    assign bus.rd_data    = rdata;
    assign bus.rd_pending = rpend;
    assign bus.init_busy  = (state_q == StClear);
endmodule
